// File: rtl/crc32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | crc32 : IEEE 802.3 FCS generator/checker for a 2-bit (RMII dibit) stream  |
// | Optional: CRC32_RESIDUE_CHECK_EN adds registered crc_ok residue flag.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module crc32 #(
  parameter logic [31:0] POLY = 32'h04C11DB7,
  parameter logic [31:0] INIT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic        axiov,
  output logic [31:0] axiod
`ifdef CRC32_RESIDUE_CHECK_EN
  ,
  output logic        crc_ok
`endif
);

  localparam logic [31:0] RESIDUE = 32'h38FB2284;

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic        axiov_q;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic d);
    logic fb;
    fb = c[31] ^ d;
    return {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
  endfunction

  // axiid[0] is the earlier wire bit, so it is folded in first.
  always_comb begin
    crc_d = crc_q;
    if (axiiv) begin
      crc_d = crc_step(crc_step(crc_q, axiid[0]), axiid[1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q   <= INIT;
      axiov_q <= 1'b0;
    end else begin
      crc_q   <= crc_d;
      axiov_q <= axiiv;
    end
  end

  assign axiov = axiov_q;
  assign axiod = ~crc_q;

`ifdef CRC32_RESIDUE_CHECK_EN
  logic seen_q;
  logic seen_d;
  logic crc_ok_q;

  assign seen_d = seen_q | axiiv;

  // Evaluated on next-state values so the flag lines up with axiod.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q   <= 1'b0;
      crc_ok_q <= 1'b0;
    end else begin
      seen_q   <= seen_d;
      crc_ok_q <= seen_d && ((~crc_d) == RESIDUE);
    end
  end

  assign crc_ok = crc_ok_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_crc32 : directed self-checking bench for crc32                        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_crc32;

  logic        clk;
  logic        rst;
  logic        axiiv;
  logic [1:0]  axiid;
  logic        axiov;
  logic [31:0] axiod;
`ifdef CRC32_RESIDUE_CHECK_EN
  logic        crc_ok;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0]  msg [0:127];
  logic [31:0] exp_fcs;
  logic [7:0]  b;

  crc32 dut (
    .clk   (clk),
    .rst   (rst),
    .axiiv (axiiv),
    .axiid (axiid),
    .axiov (axiov),
    .axiod (axiod)
`ifdef CRC32_RESIDUE_CHECK_EN
    ,
    .crc_ok(crc_ok)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: reflected (LSB-first) byte-wise CRC-32, result bit-reversed
  // into the normal-form FCS that axiod exposes.
  function automatic logic [31:0] model_fcs(input int n);
    logic [31:0] r;
    logic [31:0] f;
    r = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      r = r ^ {24'h0, msg[i]};
      for (int k = 0; k < 8; k++) begin
        r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
    end
    r = ~r;
    for (int k = 0; k < 32; k++) f[k] = r[31-k];
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_ne(input string tag, input logic [31:0] obs, input logic [31:0] notv);
    tests++;
    assert (obs !== notv) else begin
      fails++;
      $error("FAIL %s: observed %h, required anything but %h", tag, obs, notv);
    end
  endtask

  task automatic idle(input int n);
    axiiv = 1'b0;
    axiid = 2'b11;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_dibit(input logic [1:0] d);
    axiiv = 1'b1;
    axiid = d;
    @(posedge clk);
    #1;
    axiiv = 1'b0;
    axiid = 2'b11;
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    send_dibit(v[1:0]);
    send_dibit(v[3:2]);
    send_dibit(v[5:4]);
    send_dibit(v[7:6]);
    if (gap > 0) idle(gap);
  endtask

  // FCS goes out MSB first: axiid = {fcs[30], fcs[31]}, then {28,29}, ...
  task automatic send_fcs(input logic [31:0] v);
    for (int k = 31; k > 0; k -= 2) send_dibit({v[k-1], v[k]});
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    axiiv = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    axiiv = 1'b0;
    axiid = 2'b00;

    // Reset: 2 cycles high, then 5 idle cycles
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("reset_axiod", axiod, 32'h00000000);
      check("reset_axiov", {31'h0, axiov}, 32'h0);
    end

    // Single byte 0x00
    send_byte(8'h00, 0);
    check("byte00_axiod", axiod, 32'hB1F7404B);
    check("byte00_axiov", {31'h0, axiov}, 32'h1);
    idle(1);
    check("byte00_hold_axiov", {31'h0, axiov}, 32'h0);
    check("byte00_hold_axiod", axiod, 32'hB1F7404B);

    // "123456789" back to back
    do_reset();
    for (int i = 0; i < 9; i++) begin
      b = 8'h31 + 8'(i);
      send_byte(b, 0);
    end
    check("check_value", axiod, 32'h649C2FD3);

    // "123456789" with 3-cycle gaps between bytes
    do_reset();
    for (int i = 0; i < 9; i++) begin
      b = 8'h31 + 8'(i);
      send_byte(b, 3);
    end
    check("gapped_axiov", {31'h0, axiov}, 32'h0);
    check("gapped_check_value", axiod, 32'h649C2FD3);

    // 64-byte frame followed by its own FCS
    for (int i = 0; i < 64; i++) msg[i] = 8'((i * 7 + 3) & 8'hFF);
    exp_fcs = model_fcs(64);
    do_reset();
    for (int i = 0; i < 64; i++) send_byte(msg[i], 0);
    check("frame_fcs", axiod, exp_fcs);
`ifdef CRC32_RESIDUE_CHECK_EN
    check("frame_crc_ok_pre", {31'h0, crc_ok}, 32'h0);
`endif
    send_fcs(exp_fcs);
    check("frame_residue", axiod, 32'h38FB2284);
`ifdef CRC32_RESIDUE_CHECK_EN
    check("frame_crc_ok", {31'h0, crc_ok}, 32'h1);
`endif
    idle(2);
    check("frame_residue_hold", axiod, 32'h38FB2284);

    // Same frame, one payload dibit flipped, original FCS appended
    do_reset();
    for (int i = 0; i < 64; i++) send_byte((i == 20) ? (msg[i] ^ 8'h04) : msg[i], 0);
    send_fcs(exp_fcs);
    check_ne("bad_frame_residue", axiod, 32'h38FB2284);
`ifdef CRC32_RESIDUE_CHECK_EN
    check("bad_frame_crc_ok", {31'h0, crc_ok}, 32'h0);
`endif

    // Reset mid-stream with a valid dibit on the reset cycle
    do_reset();
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    rst   = 1'b1;
    axiiv = 1'b1;
    axiid = 2'b11;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    axiiv = 1'b0;
    check("midrst_axiod", axiod, 32'h00000000);
    check("midrst_axiov", {31'h0, axiov}, 32'h0);
    send_byte(8'h00, 0);
    check("midrst_byte00", axiod, 32'hB1F7404B);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
